cpu_run_ctrl: RTL
=================

// Module: cpu_run_ctrl
// PURPOSE
//   Parametrised run controller for the single-cycle RISC-V core.
//   - Sequences the core reset, then counts run cycles.
//   - Watches the core's pc/instr outputs for a halt condition (ebreak, self-loop or either).
//   - Reports done/pass/timeout with the halt PC and the cycle count.
//   - Sits beside cpu, drives its rst and observes its pc/instr; replaces fixed-delay bench timing.
// PARAMETERS
//   PC_WIDTH     8             width of the observed pc
//   INSTR_WIDTH  32            width of the observed instr
//   CNT_WIDTH    16            width of cycle_cnt
//   RST_CYCLES   2             cycles core_rst is held in RESET (>=1)
//   MAX_CYCLES   20            run-cycle budget before timeout (>=1, < 2**CNT_WIDTH)
//   STALL_LIMIT  4             consecutive unchanged-pc cycles that mean a self-loop (>=1)
//   HALT_INSTR   32'h00100073  halt opcode (ebreak); compared on INSTR_WIDTH LSBs
//   HALT_MODE    2             0 = instr match only, 1 = self-loop only, 2 = either
// PORTS
//   clk        in   1            system clock, rising edge
//   rst        in   1            asynchronous reset, active-high
//   start      in   1            1-cycle pulse: begin a run (accepted in IDLE/DONE only)
//   pc         in   PC_WIDTH     core program counter
//   instr      in   INSTR_WIDTH  core current instruction
//   core_rst   out  1            reset to the core, active-high
//   running    out  1            high while in RUN
//   done       out  1            run finished; sticky until next accepted start
//   pass       out  1            done because of halt detection
//   timeout    out  1            done because MAX_CYCLES expired without halt
//   cycle_cnt  out  CNT_WIDTH    RUN cycles elapsed in current/last run
//   halt_pc    out  PC_WIDTH     pc sampled on the halt cycle
// BEHAVIOUR
//   - All outputs are registered.
//   - rst asserted (at any time, including mid-run): state = IDLE, core_rst = 1, and
//     running/done/pass/timeout/cycle_cnt/halt_pc = 0, all immediately.
//   - FSM states: IDLE, RESET, RUN, DONE.
//   - IDLE:  core_rst = 1. start -> RESET; rst_cnt loads RST_CYCLES-1; cycle_cnt = 0.
//   - RESET: core_rst = 1. rst_cnt decrements each cycle; at 0 -> RUN.
//       core_rst falls on the same edge that sets running. start is ignored.
//   - RUN:   core_rst = 0, running = 1, cycle_cnt += 1 each cycle. start is ignored.
//     * Instr halt: instr == HALT_INSTR (HALT_MODE 0 or 2).
//     * Stall halt (HALT_MODE 1 or 2):
//       - prev_pc is registered every RUN cycle; no compare on the first RUN cycle.
//       - same_cnt increments when pc == prev_pc and clears otherwise.
//       - Halt when same_cnt reaches STALL_LIMIT.
//     * Halt seen on a cycle -> next edge: DONE, done = 1, pass = 1, halt_pc = pc of that cycle.
//     * Else, if cycle_cnt == MAX_CYCLES-1 on a cycle -> next edge: DONE, done = 1, timeout = 1.
//     * Halt and budget expiry on the same cycle: halt wins, timeout = 0.
//     * cycle_cnt counts the cycle on which the exit decision is made.
//       It holds its value in DONE and never wraps.
//   - DONE:  core_rst = 1 (core frozen), running = 0; flags and cycle_cnt hold.
//       start -> RESET, clearing done/pass/timeout/cycle_cnt/halt_pc/same_cnt on that edge.
//   - pass and timeout are mutually exclusive and are only ever 1 while done = 1.
// TESTING
//   1. rst 20 ns, pulse start, instr = 0x00100073 on the 5th RUN cycle
//      -> core_rst low for exactly 5 cycles; then done = 1, pass = 1, timeout = 0, cycle_cnt = 5.
//   2. instr never halts, pc increments by 4 each cycle, MAX_CYCLES = 20
//      -> done = 1, timeout = 1, pass = 0, cycle_cnt = 20, core_rst = 1.
//   3. HALT_MODE = 1, pc stuck at 0x10 from RUN cycle 3, STALL_LIMIT = 4
//      -> pass = 1, halt_pc = 0x10, cycle_cnt = 7.
//   4. ebreak on RUN cycle 20 with MAX_CYCLES = 20 -> pass = 1, timeout = 0, cycle_cnt = 20.
//   5. start pulsed in RESET and in RUN -> ignored; a start pulse in DONE clears all flags
//      and core_rst is held for RST_CYCLES = 2 cycles.
//   6. rst asserted mid-RUN between clock edges -> core_rst = 1 and running = 0 immediately,
//      all counters = 0, state IDLE.

Source files
------------

// File: rtl/cpu_run_ctrl_if.sv
// Connection bundle between the run controller and the core/bench side.
// The master side (the controller) observes pc/instr/start and drives the status outputs.
interface cpu_run_ctrl_if #(
    parameter int unsigned PC_WIDTH    = 8,
    parameter int unsigned INSTR_WIDTH = 32,
    parameter int unsigned CNT_WIDTH   = 16
);
    logic                   start;
    logic [PC_WIDTH-1:0]    pc;
    logic [INSTR_WIDTH-1:0] instr;
    logic                   core_rst;
    logic                   running;
    logic                   done;
    logic                   pass;
    logic                   timeout;
    logic [CNT_WIDTH-1:0]   cycle_cnt;
    logic [PC_WIDTH-1:0]    halt_pc;

    modport master (
        input  start, pc, instr,
        output core_rst, running, done, pass, timeout, cycle_cnt, halt_pc
    );

    modport slave (
        output start, pc, instr,
        input  core_rst, running, done, pass, timeout, cycle_cnt, halt_pc
    );
endinterface

// File: rtl/cpu_run_ctrl.sv
// Run controller for the single-cycle core: sequences core reset, counts run cycles,
// detects halt (ebreak and/or pc self-loop) and reports done/pass/timeout.
module cpu_run_ctrl #(
    parameter int unsigned PC_WIDTH    = 8,
    parameter int unsigned INSTR_WIDTH = 32,
    parameter int unsigned CNT_WIDTH   = 16,
    parameter int unsigned RST_CYCLES  = 2,
    parameter int unsigned MAX_CYCLES  = 20,
    parameter int unsigned STALL_LIMIT = 4,
    parameter logic [31:0] HALT_INSTR  = 32'h00100073,
    parameter int unsigned HALT_MODE   = 2
) (
    input  logic           clk,
    input  logic           rst,
    cpu_run_ctrl_if.master bus
);

    localparam int unsigned RCW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
    localparam int unsigned SCW = $clog2(STALL_LIMIT + 1);
    localparam logic [INSTR_WIDTH-1:0] HALT_MATCH = INSTR_WIDTH'(HALT_INSTR);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RESET,
        ST_RUN,
        ST_DONE
    } state_e;

    state_e               state_q;
    logic [RCW-1:0]       rst_cnt_q;
    logic [CNT_WIDTH-1:0] cycle_cnt_q;
    logic [SCW-1:0]       same_cnt_q;
    logic [PC_WIDTH-1:0]  prev_pc_q;
    logic [PC_WIDTH-1:0]  halt_pc_q;
    logic                 core_rst_q;
    logic                 running_q;
    logic                 done_q;
    logic                 pass_q;
    logic                 timeout_q;

    logic                 pc_same;
    logic                 instr_hit;
    logic                 stall_hit;
    logic                 budget_hit;
    logic [SCW-1:0]       same_cnt_d;
    logic [CNT_WIDTH-1:0] cycle_cnt_d;

    // The first RUN cycle (cycle_cnt_q == 0) has no valid prev_pc to compare against.
    always_comb begin
        pc_same     = (cycle_cnt_q != '0) && (bus.pc == prev_pc_q);
        instr_hit   = (HALT_MODE != 1) && (bus.instr == HALT_MATCH);
        stall_hit   = (HALT_MODE != 0) && pc_same &&
                      (same_cnt_q == SCW'(STALL_LIMIT - 1));
        budget_hit  = (cycle_cnt_q == CNT_WIDTH'(MAX_CYCLES - 1));
        cycle_cnt_d = cycle_cnt_q + 1'b1;
        same_cnt_d  = '0;
        if (pc_same) begin
            same_cnt_d = (same_cnt_q == SCW'(STALL_LIMIT)) ? same_cnt_q : same_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            rst_cnt_q   <= '0;
            cycle_cnt_q <= '0;
            same_cnt_q  <= '0;
            prev_pc_q   <= '0;
            halt_pc_q   <= '0;
            core_rst_q  <= 1'b1;
            running_q   <= 1'b0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.start) begin
                        state_q     <= ST_RESET;
                        rst_cnt_q   <= RCW'(RST_CYCLES - 1);
                        cycle_cnt_q <= '0;
                        same_cnt_q  <= '0;
                    end
                end
                ST_RESET: begin
                    if (rst_cnt_q == '0) begin
                        state_q    <= ST_RUN;
                        core_rst_q <= 1'b0;
                        running_q  <= 1'b1;
                    end else begin
                        rst_cnt_q <= rst_cnt_q - 1'b1;
                    end
                end
                ST_RUN: begin
                    cycle_cnt_q <= cycle_cnt_d;
                    prev_pc_q   <= bus.pc;
                    same_cnt_q  <= same_cnt_d;
                    // Halt is checked first so a halt on the last budget cycle still passes.
                    if (instr_hit || stall_hit) begin
                        state_q    <= ST_DONE;
                        done_q     <= 1'b1;
                        pass_q     <= 1'b1;
                        halt_pc_q  <= bus.pc;
                        core_rst_q <= 1'b1;
                        running_q  <= 1'b0;
                    end else if (budget_hit) begin
                        state_q    <= ST_DONE;
                        done_q     <= 1'b1;
                        timeout_q  <= 1'b1;
                        core_rst_q <= 1'b1;
                        running_q  <= 1'b0;
                    end
                end
                ST_DONE: begin
                    if (bus.start) begin
                        state_q     <= ST_RESET;
                        rst_cnt_q   <= RCW'(RST_CYCLES - 1);
                        cycle_cnt_q <= '0;
                        same_cnt_q  <= '0;
                        halt_pc_q   <= '0;
                        done_q      <= 1'b0;
                        pass_q      <= 1'b0;
                        timeout_q   <= 1'b0;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.core_rst  = core_rst_q;
    assign bus.running   = running_q;
    assign bus.done      = done_q;
    assign bus.pass      = pass_q;
    assign bus.timeout   = timeout_q;
    assign bus.cycle_cnt = cycle_cnt_q;
    assign bus.halt_pc   = halt_pc_q;

endmodule
